udp_fragment_slot_manager: RTL and testbench
============================================

# udp_fragment_slot_manager

Owns the FRAGMENT_SLOTS reassembly slots written by the UDP receive handler. Tracks each slot's occupancy and packet ID, and ages out stalled reassemblies. Schedules completed datagrams round-robin to the single downstream datagram reader, then frees each slot when the reader releases it. Sits between the receive handler (slot status in, push strobes out) and the datagram reader.

## Interface
- FRAGMENT_SLOTS, 4, number of reassembly slots; ≥2, power of two.
- AGE_LIMIT, 16'd1000, idle cycles allowed in FILLING before a slot is flushed.
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_data_valid  in  FRAGMENT_SLOTS  one-hot byte-write strobe from the handler.
- push_data_last  in  FRAGMENT_SLOTS  one-hot final-byte strobe; never asserted in the same cycle as push_data_valid.
- packet_id  in  16  IPv4 identification of the current push; sampled on the first push to an EMPTY slot.
- fragment_slot_empty  out  FRAGMENT_SLOTS  1 = slot in EMPTY state.
- fragment_slot_packet_id  out  FRAGMENT_SLOTS×16  latched packet ID per slot; 0 when EMPTY.
- datagram_valid  out  1  a completed slot is offered.
- datagram_slot  out  $clog2(FRAGMENT_SLOTS)  index of the offered slot.
- datagram_packet_id  out  16  packet ID of the offered slot.
- datagram_ready  in  1  reader accepts the offer.
- release_valid  in  1  reader has drained a slot.
- release_slot  in  $clog2(FRAGMENT_SLOTS)  slot being released.
- slot_flush  out  FRAGMENT_SLOTS  one-cycle pulse; slot discarded, so slot storage must reset its pointers.
- protocol_error  out  1  one-cycle pulse on an illegal strobe.

## Operation
- Each slot has its own state: EMPTY → FILLING → COMPLETE → GRANTED → EMPTY.
- EMPTY + push_data_valid[i] → FILLING; latch packet_id; clear the age counter.
- FILLING + push_data_valid[i] → clear the age counter. FILLING + push_data_last[i] → COMPLETE.
- COMPLETE: eligible for scheduling. GRANTED: waits for release_valid with release_slot == i, then → EMPTY.
- Scheduler:
  - Registered offer. When datagram_valid=0, pick the first COMPLETE slot strictly after the last granted index (wrap FRAGMENT_SLOTS-1 → 0).
  - Drive datagram_valid/slot/packet_id from the next cycle.
  - Offer is held stable until datagram_valid && datagram_ready. On that handshake, slot → GRANTED, the last-grant pointer updates, and datagram_valid drops for at least 1 cycle.
- Any number of slots may be GRANTED at once.
- Ignored events, each pulsing protocol_error:
  - push_data_last to EMPTY: slot stays EMPTY.
  - push to COMPLETE or GRANTED: no state change.
  - release of a slot not in GRANTED.
- Simultaneous events:
  - push_data_last vs. aging expiry in the same cycle: last wins, the slot goes COMPLETE.
  - release_valid and a new push to the released slot in the same cycle: the release takes effect; the push sees the old state (GRANTED) and raises protocol_error.

## Timing
- Reset values: fragment_slot_empty all 1; fragment_slot_packet_id 0; datagram_valid 0; datagram_slot 0; datagram_packet_id 0; slot_flush 0; protocol_error 0. Last-grant pointer = FRAGMENT_SLOTS-1, so slot 0 is served first.
- Reset mid-operation discards all slots without pulsing slot_flush.
- fragment_slot_empty[i] falls the cycle after the first push_data_valid[i], and rises the cycle after the release handshake or the flush.
- A slot going COMPLETE at edge N produces datagram_valid at edge N+1 at the earliest, if no offer is pending.
- Age counter: 16-bit, saturating. Increments each FILLING cycle without push_data_valid[i].
- Expiry: on the cycle where the counter == AGE_LIMIT-1 and no push occurs, slot → EMPTY and slot_flush[i] pulses the next cycle.

## Configuration
- UDP_FRAGMENT_AGING_EN defined: age counters, expiry and slot_flush are implemented as above.
- Not defined: no age counters. slot_flush is tied to 0, and a FILLING slot leaves FILLING only via push_data_last or reset.

## Test plan
- Reset, then push_data_valid[0] with packet_id=16'hBEEF, then push_data_last[0] → fragment_slot_empty=4'b1110, packet_id[0]=BEEF, datagram_valid with slot 0 and BEEF, one cycle after last.
- Complete slots 2 and 1 in the same cycle, datagram_ready held 1 → offers slot 1, then slot 2, with ≥1 idle cycle between; then release 1 and release 2 → empty=4'b1111.
- datagram_ready=0 for 10 cycles with slot 3 offered, then slot 0 completes → offer stays slot 3 and stable; after the handshake, slot 0 is offered next.
- With aging enabled and AGE_LIMIT=8, push once to slot 2, then idle → slot_flush=4'b0100 pulse after 8 idle cycles; empty[2]=1. With the macro undefined → no flush after 1000 cycles.
- push_data_last[1] in the same cycle as expiry → slot 1 COMPLETE, no flush.
- release_slot=3 while slot 3 is FILLING → protocol_error single pulse, slot 3 unchanged.

Source files
------------

// File: rtl/udp_fragment_slot_manager.sv
// Reassembly slot bookkeeping and round-robin scheduler feeding one datagram reader.
// Define UDP_FRAGMENT_AGING_EN to build the per-slot age counters, expiry and slot_flush.
module udp_fragment_slot_manager #(
  parameter int unsigned FRAGMENT_SLOTS = 4,
  parameter logic [15:0] AGE_LIMIT      = 16'd1000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [FRAGMENT_SLOTS-1:0]         push_data_valid,
  input  logic [FRAGMENT_SLOTS-1:0]         push_data_last,
  input  logic [15:0]                       packet_id,
  output logic [FRAGMENT_SLOTS-1:0]         fragment_slot_empty,
  output logic [FRAGMENT_SLOTS*16-1:0]      fragment_slot_packet_id,
  output logic                              datagram_valid,
  output logic [$clog2(FRAGMENT_SLOTS)-1:0] datagram_slot,
  output logic [15:0]                       datagram_packet_id,
  input  logic                              datagram_ready,
  input  logic                              release_valid,
  input  logic [$clog2(FRAGMENT_SLOTS)-1:0] release_slot,
  output logic [FRAGMENT_SLOTS-1:0]         slot_flush,
  output logic                              protocol_error
);

  localparam int unsigned IDX_W = $clog2(FRAGMENT_SLOTS);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_COMPLETE,
    S_GRANTED
  } slot_state_t;

  if (FRAGMENT_SLOTS < 2 || (FRAGMENT_SLOTS & (FRAGMENT_SLOTS - 1)) != 0 ||
      AGE_LIMIT == 16'd0) begin : g_bad_params
    $error("udp_fragment_slot_manager: FRAGMENT_SLOTS must be a power of two >= 2 and AGE_LIMIT nonzero");
  end

  slot_state_t               state_q [FRAGMENT_SLOTS];
  slot_state_t               state_d [FRAGMENT_SLOTS];
  logic [15:0]               pid_q   [FRAGMENT_SLOTS];
  logic [15:0]               pid_d   [FRAGMENT_SLOTS];
  logic [FRAGMENT_SLOTS-1:0] rel_hit;
  logic                      err_d, err_q;
  logic                      handshake;

  logic                      offer_valid_q, offer_valid_d;
  logic [IDX_W-1:0]          offer_slot_q, offer_slot_d;
  logic [15:0]               offer_pid_q, offer_pid_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [IDX_W-1:0]          cand;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_found;

  assign handshake = offer_valid_q && datagram_ready;

`ifdef UDP_FRAGMENT_AGING_EN
  logic [15:0]               age_q [FRAGMENT_SLOTS];
  logic [FRAGMENT_SLOTS-1:0] expire, flush_d, flush_q;

  always_comb begin
    expire = '0;
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      expire[i] = (state_q[i] == S_FILLING) && !push_data_valid[i] &&
                  (age_q[i] == AGE_LIMIT - 16'd1);
    end
  end

  // Age counts idle FILLING cycles and saturates so a huge AGE_LIMIT cannot wrap.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      if (reset || state_q[i] != S_FILLING || push_data_valid[i]) begin
        age_q[i] <= '0;
      end else if (age_q[i] != 16'hFFFF) begin
        age_q[i] <= age_q[i] + 16'd1;
      end
    end
    if (reset) flush_q <= '0;
    else       flush_q <= flush_d;
  end

  assign slot_flush = flush_q;
`else
  assign slot_flush = '0;
`endif

  always_comb begin
    rel_hit = '0;
    if (release_valid) rel_hit[release_slot] = 1'b1;
  end

  always_comb begin
    err_d = 1'b0;
`ifdef UDP_FRAGMENT_AGING_EN
    flush_d = '0;
`endif
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      state_d[i] = state_q[i];
      pid_d[i]   = pid_q[i];
      unique case (state_q[i])
        S_EMPTY: begin
          if (push_data_valid[i]) begin
            state_d[i] = S_FILLING;
            pid_d[i]   = packet_id;
          end
          if (push_data_last[i] || rel_hit[i]) err_d = 1'b1;
        end
        S_FILLING: begin
          if (rel_hit[i]) err_d = 1'b1;
          // A final byte beats a same-cycle expiry.
          if (push_data_last[i]) begin
            state_d[i] = S_COMPLETE;
          end
`ifdef UDP_FRAGMENT_AGING_EN
          else if (expire[i]) begin
            state_d[i] = S_EMPTY;
            pid_d[i]   = '0;
            flush_d[i] = 1'b1;
          end
`endif
        end
        S_COMPLETE: begin
          if (push_data_valid[i] || push_data_last[i] || rel_hit[i]) err_d = 1'b1;
          if (handshake && offer_slot_q == IDX_W'(i)) state_d[i] = S_GRANTED;
        end
        S_GRANTED: begin
          if (push_data_valid[i] || push_data_last[i]) err_d = 1'b1;
          if (rel_hit[i]) begin
            state_d[i] = S_EMPTY;
            pid_d[i]   = '0;
          end
        end
        default: state_d[i] = S_EMPTY;
      endcase
    end
  end

  // Scheduler: search starts just after the last granted slot and wraps.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= FRAGMENT_SLOTS; k++) begin
      cand = IDX_W'(int'(last_grant_q) + k);
      if (!pick_found && state_q[cand] == S_COMPLETE) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end

    offer_valid_d = offer_valid_q;
    offer_slot_d  = offer_slot_q;
    offer_pid_d   = offer_pid_q;
    last_grant_d  = last_grant_q;
    if (offer_valid_q) begin
      if (datagram_ready) begin
        offer_valid_d = 1'b0;
        last_grant_d  = offer_slot_q;
      end
    end else if (pick_found) begin
      offer_valid_d = 1'b1;
      offer_slot_d  = pick_idx;
      offer_pid_d   = pid_q[pick_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
        state_q[i] <= S_EMPTY;
        pid_q[i]   <= '0;
      end
      err_q         <= 1'b0;
      offer_valid_q <= 1'b0;
      offer_slot_q  <= '0;
      offer_pid_q   <= '0;
      last_grant_q  <= IDX_W'(FRAGMENT_SLOTS - 1);
    end else begin
      for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        pid_q[i]   <= pid_d[i];
      end
      err_q         <= err_d;
      offer_valid_q <= offer_valid_d;
      offer_slot_q  <= offer_slot_d;
      offer_pid_q   <= offer_pid_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    fragment_slot_empty     = '0;
    fragment_slot_packet_id = '0;
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      fragment_slot_empty[i]             = (state_q[i] == S_EMPTY);
      fragment_slot_packet_id[i*16 +: 16] = pid_q[i];
    end
  end

  assign datagram_valid     = offer_valid_q;
  assign datagram_slot      = offer_slot_q;
  assign datagram_packet_id = offer_pid_q;
  assign protocol_error     = err_q;

endmodule

// File: tb/tb_udp_fragment_slot_manager.sv
// Directed bench for udp_fragment_slot_manager with a per-cycle reference model and literal spot checks.
`timescale 1ns/1ps
module tb_udp_fragment_slot_manager;

`ifdef UDP_FRAGMENT_AGING_EN
  localparam logic [15:0] AGE   = 16'd8;
  localparam bit          AGING = 1'b1;
`else
  localparam logic [15:0] AGE   = 16'd1000;
  localparam bit          AGING = 1'b0;
`endif
  localparam int N = 4;
  localparam int FREE = 0, COLLECT = 1, READY = 2, TAKEN = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  push_data_valid, push_data_last;
  logic [15:0] packet_id;
  logic [3:0]  fragment_slot_empty;
  logic [63:0] fragment_slot_packet_id;
  logic        datagram_valid;
  logic [1:0]  datagram_slot;
  logic [15:0] datagram_packet_id;
  logic        datagram_ready, release_valid;
  logic [1:0]  release_slot;
  logic [3:0]  slot_flush;
  logic        protocol_error;

  udp_fragment_slot_manager #(.FRAGMENT_SLOTS(N), .AGE_LIMIT(AGE)) dut (
    .clock(clock), .reset(reset),
    .push_data_valid(push_data_valid), .push_data_last(push_data_last),
    .packet_id(packet_id),
    .fragment_slot_empty(fragment_slot_empty),
    .fragment_slot_packet_id(fragment_slot_packet_id),
    .datagram_valid(datagram_valid), .datagram_slot(datagram_slot),
    .datagram_packet_id(datagram_packet_id), .datagram_ready(datagram_ready),
    .release_valid(release_valid), .release_slot(release_slot),
    .slot_flush(slot_flush), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each slot holds and what the reader is being offered.
  int          m_phase [N];
  logic [15:0] m_id    [N];
  int          m_idle  [N];
  int          m_last;
  bit          m_off_v;
  int          m_off_slot;
  logic [15:0] m_off_id;
  logic [3:0]  m_flush;
  bit          m_err;
  bit          m_known = 1'b0;
  logic [3:0]  exp_empty;
  logic [63:0] exp_pid;

  bit          lit_req = 1'b0;
  int          lit_sel;
  logic [63:0] lit_exp;
  string       lit_name;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lit_actual(input int sel);
    case (sel)
      0: return 64'(fragment_slot_empty);
      1: return 64'(datagram_valid);
      2: return 64'(datagram_slot);
      3: return 64'(datagram_packet_id);
      4: return 64'(slot_flush);
      5: return 64'(protocol_error);
      default: return 64'(fragment_slot_packet_id[(sel-6)*16 +: 16]);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = FREE;
      m_id[i]    = 16'h0;
      m_idle[i]  = 0;
    end
    m_last     = N - 1;
    m_off_v    = 1'b0;
    m_off_slot = 0;
    m_off_id   = 16'h0;
    m_flush    = 4'b0;
    m_err      = 1'b0;
  endtask

  task automatic model_step();
    bit         hs;
    int         hs_slot;
    bit         found;
    int         j;
    bit         rel;
    logic [3:0] nflush;
    bit         nerr;
    hs      = m_off_v && datagram_ready;
    hs_slot = m_off_slot;
    nflush  = 4'b0;
    nerr    = 1'b0;
    if (m_off_v) begin
      if (datagram_ready) begin
        m_off_v = 1'b0;
        m_last  = m_off_slot;
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && m_phase[j] == READY) begin
          found      = 1'b1;
          m_off_v    = 1'b1;
          m_off_slot = j;
          m_off_id   = m_id[j];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      rel = release_valid && (int'(release_slot) == i);
      case (m_phase[i])
        FREE: begin
          if (push_data_last[i] || rel) nerr = 1'b1;
          if (push_data_valid[i]) begin
            m_phase[i] = COLLECT;
            m_id[i]    = packet_id;
            m_idle[i]  = 0;
          end
        end
        COLLECT: begin
          if (rel) nerr = 1'b1;
          if (push_data_last[i]) m_phase[i] = READY;
          else if (push_data_valid[i]) m_idle[i] = 0;
          else begin
            m_idle[i]++;
            if (AGING && m_idle[i] == int'(AGE)) begin
              m_phase[i] = FREE;
              m_id[i]    = 16'h0;
              nflush[i]  = 1'b1;
            end
          end
        end
        READY: begin
          if (push_data_valid[i] || push_data_last[i] || rel) nerr = 1'b1;
          if (hs && hs_slot == i) m_phase[i] = TAKEN;
        end
        default: begin
          if (push_data_valid[i] || push_data_last[i]) nerr = 1'b1;
          if (rel) begin
            m_phase[i] = FREE;
            m_id[i]    = 16'h0;
          end
        end
      endcase
    end
    m_flush = nflush;
    m_err   = nerr;
  endtask

  always @(negedge clock) begin
    if (m_known) begin
      for (int i = 0; i < N; i++) begin
        exp_empty[i]         = (m_phase[i] == FREE);
        exp_pid[i*16 +: 16]  = m_id[i];
      end
      chk("empty", 64'(fragment_slot_empty), 64'(exp_empty));
      chk("slot_pid", fragment_slot_packet_id, exp_pid);
      chk("dg_valid", 64'(datagram_valid), 64'(m_off_v));
      if (m_off_v) begin
        chk("dg_slot", 64'(datagram_slot), 64'(m_off_slot));
        chk("dg_pid", 64'(datagram_packet_id), 64'(m_off_id));
      end
      chk("flush", 64'(slot_flush), 64'(m_flush));
      chk("perr", 64'(protocol_error), 64'(m_err));
    end
    if (lit_req) chk(lit_name, lit_actual(lit_sel), lit_exp);
    if (reset) begin
      model_reset();
      m_known = 1'b1;
    end else if (m_known) begin
      model_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    lit_req = 1'b0;
  endtask

  task automatic lit(input string name, input int sel, input logic [63:0] e);
    lit_name = name;
    lit_sel  = sel;
    lit_exp  = e;
    lit_req  = 1'b1;
  endtask

  task automatic idle();
    push_data_valid = 4'b0;
    push_data_last  = 4'b0;
    release_valid   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; idle(); packet_id = 16'h0; datagram_ready = 1'b0; release_slot = 2'd0;
    tick(); tick();
    lit("rst_empty", 0, 64'hF);
    tick(); lit("rst_valid", 1, 64'h0);
    tick(); lit("rst_slot", 2, 64'h0);
    tick(); lit("rst_dpid", 3, 64'h0);
    reset = 1'b0;
    tick();

    // Single datagram through slot 0.
    push_data_valid = 4'b0001; packet_id = 16'hBEEF; tick(); idle(); packet_id = 16'h0;
    lit("t1_empty", 0, 64'b1110);
    push_data_last = 4'b0001; tick(); idle();
    lit("t1_pid0", 6, 64'hBEEF);
    tick(); lit("t1_valid", 1, 64'h1);
    tick(); lit("t1_slot", 2, 64'h0);
    tick(); lit("t1_dpid", 3, 64'hBEEF);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    lit("t1_drop", 1, 64'h0);
    release_valid = 1'b1; release_slot = 2'd0; tick(); idle();
    lit("t1_free", 0, 64'hF);

    // Slots 1 and 2 complete together; round-robin serves 1 then 2.
    push_data_valid = 4'b0010; packet_id = 16'h1111; tick();
    push_data_valid = 4'b0100; packet_id = 16'h2222; tick(); idle();
    push_data_last = 4'b0110; datagram_ready = 1'b1; tick(); idle();
    tick(); lit("t2_first", 2, 64'h1);
    tick(); lit("t2_gap", 1, 64'h0);
    tick(); lit("t2_second", 2, 64'h2);
    tick(); datagram_ready = 1'b0; lit("t2_gap2", 1, 64'h0);
    release_valid = 1'b1; release_slot = 2'd1; tick();
    release_slot = 2'd2; tick(); idle();
    lit("t2_free", 0, 64'hF);

    // Offer of slot 3 held while slot 0 completes behind it.
    push_data_valid = 4'b1000; packet_id = 16'h3333; tick(); idle();
    push_data_last = 4'b1000; tick(); idle();
    tick(); lit("t3_offer", 2, 64'h3);
    push_data_valid = 4'b0001; packet_id = 16'h0A0A; tick(); idle();
    push_data_last = 4'b0001; tick(); idle();
    for (int k = 0; k < 8; k++) tick();
    lit("t3_hold", 2, 64'h3);
    tick(); lit("t3_hold_pid", 3, 64'h3333);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    tick(); lit("t3_next", 2, 64'h0);
    tick(); lit("t3_next_pid", 3, 64'h0A0A);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    release_valid = 1'b1; release_slot = 2'd3; tick();
    release_slot = 2'd0; tick(); idle();
    lit("t3_free", 0, 64'hF);

    // Illegal strobes.
    push_data_valid = 4'b1000; packet_id = 16'h4444; tick(); idle();
    release_valid = 1'b1; release_slot = 2'd3; tick(); idle();
    lit("t6_rel_filling", 5, 64'h1);
    tick(); lit("t6_err_once", 5, 64'h0);
    tick(); lit("t6_unchanged", 0, 64'b0111);
    push_data_last = 4'b0001; tick(); idle();
    lit("t6_last_empty", 5, 64'h1);
    tick(); lit("t6_last_empty_state", 0, 64'b0111);
    push_data_last = 4'b1000; tick(); idle();
    push_data_valid = 4'b1000; tick(); idle();
    lit("t6_push_complete", 5, 64'h1);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    release_valid = 1'b1; release_slot = 2'd3; push_data_valid = 4'b1000;
    packet_id = 16'h7777; tick(); idle();
    lit("t6_rel_push_err", 5, 64'h1);
    tick(); lit("t6_rel_push_free", 0, 64'hF);

`ifdef UDP_FRAGMENT_AGING_EN
    // Stalled slot 2 is flushed after AGE idle cycles.
    push_data_valid = 4'b0100; packet_id = 16'h5555; tick(); idle();
    for (int k = 0; k < 7; k++) tick();
    lit("t4_no_flush_yet", 4, 64'h0);
    tick(); lit("t4_flush", 4, 64'b0100);
    tick(); lit("t4_flush_once", 4, 64'h0);
    tick(); lit("t4_empty", 0, 64'hF);
    // Final byte on the expiry cycle wins.
    push_data_valid = 4'b0010; packet_id = 16'h6666; tick(); idle();
    for (int k = 0; k < 7; k++) tick();
    push_data_last = 4'b0010; tick(); idle();
    lit("t5_no_flush", 4, 64'h0);
    tick(); lit("t5_offer", 2, 64'h1);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    release_valid = 1'b1; release_slot = 2'd1; tick(); idle();
`else
    // Without aging a stalled slot stays FILLING indefinitely.
    push_data_valid = 4'b0100; packet_id = 16'h5555; tick(); idle();
    for (int k = 0; k < 1000; k++) tick();
    lit("t4_no_flush", 4, 64'h0);
    tick(); lit("t4_still_filling", 0, 64'b1011);
    push_data_last = 4'b0100; tick(); idle();
    tick(); lit("t5_offer", 2, 64'h2);
    datagram_ready = 1'b1; tick(); datagram_ready = 1'b0;
    release_valid = 1'b1; release_slot = 2'd2; tick(); idle();
`endif
    tick(); lit("end_empty", 0, 64'hF);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
